addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, bit-serial two's-complement adder/subtractor with start/done handshake and registered status flags. It generalises the team's 4-bit combinational subtractor to any width, adds an add/subtract mode and optional saturation, and trades latency for area by processing one bit per clock, LSB first. It sits in the datapath wherever a small shared arithmetic unit serves a sequencer, and reports the same Overflow/Negative/Zero flags plus an unsigned Carry.

## Interface
- WIDTH, 4: operand/result width in bits, 2 or more.
- SAT, 0: 1 = clamp signed overflow to the most positive/most negative value; 0 = wrap.
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = A+B, 1 = A−B; sampled with start.
- A  input  WIDTH  signed operand A; sampled with start.
- B  input  WIDTH  signed operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when results are updated.
- D  output  WIDTH  result (wrapped or saturated).
- Overflow  output  1  signed overflow of the true result.
- Negative  output  1  sign of the true (infinite-precision) result.
- Zero  output  1  D == 0.
- Carry  output  1  carry out of MSB; in subtract this is "no borrow" (A ≥ B unsigned).

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: when start=1, latch A and B into shift registers. For subtraction, store ~B. Load the carry flop with mode. Clear the bit counter. Go to RUN.
- RUN: each cycle, compute sum bit i = a0 ^ b0 ^ c with a 1-bit full adder. Shift the sum into the result register MSB-first-in so the LSB ends at bit 0. Shift the operands right. Update the carry.
  - On the cycle for bit WIDTH−1, also capture the carry into MSB (c_msb) and the carry out (c_out).
  - After WIDTH bits, go to DONE.
- DONE: register the outputs and pulse done, then go to IDLE.
  - Overflow = c_msb ^ c_out.
  - Carry = c_out.
  - Negative = r[WIDTH−1] ^ Overflow.
  - D: if SAT=1 and Overflow=1, D = Negative ? 1000…0 : 0111…1. Otherwise D = r.
  - Zero = (D == 0).
- start is ignored while busy. A, B and mode may change freely after acceptance.
- D and the flags hold their last values until the next DONE.
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, D=0, Overflow=0, Negative=0, Zero=0, Carry=0; internal registers cleared. Reset in RUN or DONE aborts the operation; no done pulse is produced for it.

## Timing
- start accepted at edge s. Then busy=1 from s+1 through s+WIDTH+1.
- Bit i is computed at edge s+1+i.
- done=1 and the new D/flags are visible after edge s+WIDTH+1.
- Total latency is WIDTH+1 cycles from acceptance to done.
- The earliest next acceptance is edge s+WIDTH+2, so throughput is one operation per WIDTH+2 cycles. start held high continuously gives back-to-back operations at that rate.
- start asserted during the DONE cycle is ignored and is not queued.

## Structure
- Package addsub_pkg holds:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - The state encoding: IDLE, RUN, DONE as a 2-bit enumerated type.
- Sub-module full_adder_1b: inputs a, b, cin; outputs s, cout. It is combinational and instantiated once.
- The counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=4, SAT=0, SUB:
  - 7−2 → D=0x5, Ov=0, N=0, Z=0, C=1.
  - 3−5 → D=0xE (−2), Ov=0, N=1, C=0.
  - −3−5 → D=0x8 (−8), Ov=0, N=1.
  - In every case done arrives exactly 5 cycles after start.
- WIDTH=4, SUB overflow:
  - 7−(−2) → SAT=0: D=0x9, Ov=1, N=0. SAT=1: D=0x7, Ov=1, N=0.
  - −8−1 → SAT=0: D=0x7, Ov=1, N=1. SAT=1: D=0x8.
- WIDTH=4, ADD:
  - 7+1 → D=0x8, Ov=1, N=0, C=0.
  - −1+1 → D=0x0, Z=1, C=1, Ov=0.
  - 5−5 (SUB) → D=0, Z=1, C=1.
- Handshake:
  - start pulsed again at s+2 (busy) → ignored; exactly one done, at s+5.
  - start held high → done at s+5, s+11, s+17, with busy low for one cycle between operations.
- Reset: rst_n=0 at s+3 mid-RUN → all outputs 0 on the next cycle, no done. A new start after release completes normally with correct results.
- WIDTH=8, SAT=1: 100−(−100) → D=0x7F, Ov=1. −128+(−1) → D=0x80, Ov=1, N=1. Each done arrives 9 cycles after start.

Source files
------------

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared mode constants and state encoding for addsub_serial
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - combinational one-bit full adder
// Ports: a, b, cin - addend bits and carry in; s - sum bit; cout - carry out.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - bit-serial signed adder/subtractor with start/done handshake
// Ports: clk, rst_n (sync active-low); start/mode/A/B request, sampled in IDLE;
//        busy high in RUN and DONE; done one-cycle pulse with D/Overflow/Negative/Zero/Carry
//        updated together and held until the next operation completes.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Overflow,
    output logic             Negative,
    output logic             Zero,
    output logic             Carry
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             c_msb;
    logic             c_out;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_cout;

    logic             ov;
    logic             neg;
    logic [WIDTH-1:0] d_next;

    full_adder_1b u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sign of the true result is the result MSB, flipped when it overflowed.
    always_comb begin
        ov     = c_msb ^ c_out;
        neg    = r[WIDTH-1] ^ ov;
        d_next = r;
        if (SAT && ov) begin
            d_next = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r        <= '0;
            c        <= 1'b0;
            c_msb    <= 1'b0;
            c_out    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            D        <= '0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                        a_sh  <= A;
                        b_sh  <= (mode == MODE_SUB) ? ~B : B;
                        c     <= mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the top so the first (LSB) ends at bit 0.
                    r    <= {fa_s, r[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= fa_cout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        c_msb <= c;
                        c_out <= fa_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    D        <= d_next;
                    Overflow <= ov;
                    Negative <= neg;
                    Zero     <= (d_next == '0);
                    Carry    <= c_out;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - self-checking bench for addsub_serial
module tb_addsub_serial;

    typedef struct packed {
        logic [7:0] d;
        logic       ov;
        logic       neg;
        logic       z;
        logic       c;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic       mode4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       start8 = 1'b0;
    logic       mode8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;

    logic       busy_0, done_0, ov_0, neg_0, z_0, c_0;
    logic [3:0] d_0;
    logic       busy_1, done_1, ov_1, neg_1, z_1, c_1;
    logic [3:0] d_1;
    logic       busy_8, done_8, ov_8, neg_8, z_8, c_8;
    logic [7:0] d_8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(4), .SAT(1'b0)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .A(a4), .B(b4),
        .busy(busy_0), .done(done_0), .D(d_0), .Overflow(ov_0), .Negative(neg_0),
        .Zero(z_0), .Carry(c_0)
    );

    addsub_serial #(.WIDTH(4), .SAT(1'b1)) dut_w4s (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .A(a4), .B(b4),
        .busy(busy_1), .done(done_1), .D(d_1), .Overflow(ov_1), .Negative(neg_1),
        .Zero(z_1), .Carry(c_1)
    );

    addsub_serial #(.WIDTH(8), .SAT(1'b1)) dut_w8s (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .A(a8), .B(b8),
        .busy(busy_8), .done(done_8), .D(d_8), .Overflow(ov_8), .Negative(neg_8),
        .Zero(z_8), .Carry(c_8)
    );

    // Reference: exact integer result, then range test, wrap/clamp and unsigned carry.
    function automatic res_t model(input int w, input bit sat, input int a, input int b, input bit m);
        res_t r;
        int t, mx, mn, mask, dv, ua, ub;
        t    = m ? (a - b) : (a + b);
        mx   = (1 << (w - 1)) - 1;
        mn   = -(1 << (w - 1));
        mask = (1 << w) - 1;
        r.ov  = (t > mx) || (t < mn);
        r.neg = (t < 0);
        dv    = t & mask;
        if (sat && r.ov) dv = r.neg ? (mn & mask) : mx;
        r.d = dv[7:0];
        r.z = (dv == 0);
        ua  = a & mask;
        ub  = b & mask;
        r.c = m ? (ua >= ub) : ((((ua + ub) >> w) & 1) != 0);
        return r;
    endfunction

    task automatic do_op(input bit w8, input int a, input int b, input bit m);
        res_t e0, e1, e8;
        int   lat;
        int   want;
        bit   seen;
        want = w8 ? 9 : 5;
        seen = 1'b0;
        lat  = 0;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; mode8 = m; start8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; mode4 = m; start4 = 1'b1;
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (w8 ? done_8 : done_0) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
            n_checks++;
            if ((w8 ? busy_8 : busy_0) !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_run cycle %0d: got %b want 1", k, w8 ? busy_8 : busy_0);
            end
        end
        n_checks++;
        if (!seen || lat != want) begin
            n_fail++;
            $display("FAIL latency a=%0d b=%0d m=%0d: got %0d (seen=%0d) want %0d", a, b, m, lat, seen, want);
        end
        if (!seen) return;
        if (w8) begin
            e8 = model(8, 1'b1, a, b, m);
            n_checks++;
            if ({d_8, ov_8, neg_8, z_8, c_8, busy_8} !== {e8, 1'b0}) begin
                n_fail++;
                $display("FAIL w8sat a=%0d b=%0d m=%0d: got D=%h ov%b n%b z%b c%b busy%b want D=%h ov%b n%b z%b c%b busy0",
                         a, b, m, d_8, ov_8, neg_8, z_8, c_8, busy_8, e8.d, e8.ov, e8.neg, e8.z, e8.c);
            end
        end else begin
            e0 = model(4, 1'b0, a, b, m);
            e1 = model(4, 1'b1, a, b, m);
            n_checks++;
            if ({4'h0, d_0, ov_0, neg_0, z_0, c_0, busy_0} !== {e0, 1'b0}) begin
                n_fail++;
                $display("FAIL w4wrap a=%0d b=%0d m=%0d: got D=%h ov%b n%b z%b c%b busy%b want D=%h ov%b n%b z%b c%b busy0",
                         a, b, m, d_0, ov_0, neg_0, z_0, c_0, busy_0, e0.d, e0.ov, e0.neg, e0.z, e0.c);
            end
            n_checks++;
            if ({done_1, 4'h0, d_1, ov_1, neg_1, z_1, c_1} !== {1'b1, e1}) begin
                n_fail++;
                $display("FAIL w4sat a=%0d b=%0d m=%0d: got done%b D=%h ov%b n%b z%b c%b want done1 D=%h ov%b n%b z%b c%b",
                         a, b, m, done_1, d_1, ov_1, neg_1, z_1, c_1, e1.d, e1.ov, e1.neg, e1.z, e1.c);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_0, done_0, d_0, ov_0, neg_0, z_0, c_0, busy_1, done_1, d_1,
             busy_8, done_8, d_8, ov_8, neg_8, z_8, c_8} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: w4 busy%b done%b D=%h w4s D=%h w8 busy%b done%b D=%h want all 0",
                     busy_0, done_0, d_0, d_1, busy_8, done_8, d_8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(1'b0,  7,  2, 1'b1);
        do_op(1'b0,  3,  5, 1'b1);
        do_op(1'b0, -3,  5, 1'b1);
        do_op(1'b0,  7, -2, 1'b1);
        do_op(1'b0, -8,  1, 1'b1);
        do_op(1'b0,  7,  1, 1'b0);
        do_op(1'b0, -1,  1, 1'b0);
        do_op(1'b0,  5,  5, 1'b1);
        do_op(1'b0, -8, -8, 1'b0);
        n_checks++;
        if ({d_1, ov_1, neg_1} !== {4'h8, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_neg_clamp: got D=%h ov%b n%b want D=8 ov1 n1", d_1, ov_1, neg_1);
        end
    endtask

    task automatic test_random4();
        for (int i = 0; i < 30; i++) begin
            do_op(1'b0, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int at;
        ndone = 0;
        at    = 0;
        @(negedge clk);
        a4 = 4'd6; b4 = 4'd2; mode4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(posedge clk);
        #1 start4 = 1'b1;
        a4 = 4'd1; b4 = 4'd1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int off = 3; off <= 14; off++) begin
            @(posedge clk);
            #1;
            if (done_0) begin
                ndone++;
                at = off;
            end
        end
        n_checks++;
        if (ndone != 1 || at != 5 || d_0 !== 4'h8) begin
            n_fail++;
            $display("FAIL ignore_start: got %0d done(s), last at +%0d, D=%h want 1 at +5 D=8", ndone, at, d_0);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_done;
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd1; mode4 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        for (int off = 1; off <= 17; off++) begin
            @(posedge clk);
            #1;
            exp_done = (off % 6 == 5);
            n_checks++;
            if (done_0 !== exp_done || busy_0 !== !exp_done) begin
                n_fail++;
                $display("FAIL back_to_back +%0d: got done%b busy%b want done%b busy%b",
                         off, done_0, busy_0, exp_done, !exp_done);
            end
            if (exp_done) begin
                n_checks++;
                if (d_0 !== 4'h2) begin
                    n_fail++;
                    $display("FAIL back_to_back_D +%0d: got %h want 2", off, d_0);
                end
            end
        end
        start4 = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit any_done;
        any_done = 1'b0;
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd2; mode4 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy_0, done_0, d_0, ov_0, neg_0, z_0, c_0, busy_1, d_1} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy%b done%b D=%h ov%b n%b z%b c%b sD=%h want all 0",
                     busy_0, done_0, d_0, ov_0, neg_0, z_0, c_0, d_1);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done_0 || done_1) any_done = 1'b1;
        end
        n_checks++;
        if (any_done) begin
            n_fail++;
            $display("FAIL reset_no_done: got a done pulse want none");
        end
        do_op(1'b0, 7, 2, 1'b1);
    endtask

    task automatic test_w8();
        do_op(1'b1, 100, -100, 1'b1);
        do_op(1'b1, -128, -1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            do_op(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random4();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
